// File: rtl/conv_pkg.sv
// Shared state encoding and pad-mode constants for the convolution window scanner.
package conv_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } scanState_e;

    localparam logic PAD_ZERO = 1'b0;
    localparam logic PAD_REPL = 1'b1;

endpackage

// File: rtl/conv_tap_fifo.sv
// Two-entry FIFO holding {data,last,waddr} taps between the read pipeline and the MAC.
module conv_tap_fifo
#(
    parameter int W = 30
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         pushEn_i,
    input  logic [W-1:0] pushData_i,
    input  logic         popEn_i,
    output logic         valid_o,
    output logic [W-1:0] popData_o,
    output logic [1:0]   count_o
);

    logic [W-1:0] mem_q [2];
    logic         wrPtr_q;
    logic         rdPtr_q;
    logic [1:0]   count_q;
    logic         doPop;

    // The producer only pushes when credit guarantees a free slot.
    assign doPop = popEn_i && (count_q != 2'd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            wrPtr_q <= 1'b0;
            rdPtr_q <= 1'b0;
            count_q <= 2'd0;
        end else begin
            if (pushEn_i) begin
                wrPtr_q <= ~wrPtr_q;
            end
            if (doPop) begin
                rdPtr_q <= ~rdPtr_q;
            end
            count_q <= count_q + {1'b0, pushEn_i} - {1'b0, doPop};
        end
    end

    always_ff @(posedge clk) begin
        if (pushEn_i) begin
            mem_q[wrPtr_q] <= pushData_i;
        end
    end

    assign valid_o   = (count_q != 2'd0);
    assign popData_o = valid_o ? mem_q[rdPtr_q] : '0;
    assign count_o   = count_q;

endmodule

// File: rtl/conv_window_scanner.sv
// Walks an image window by window, issuing KxK padded taps from image RAM
// and streaming them to the filter MAC over a credit-limited ready/valid FIFO.
module conv_window_scanner
    import conv_pkg::*;
#(
    parameter int ADDR_W = 17,
    parameter int DATA_W = 12,
    parameter int DIM_W  = 8,
    parameter int K      = 5,
    parameter int STRIDE = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DIM_W-1:0]  cfg_rows,
    input  logic [DIM_W-1:0]  cfg_cols,
    input  logic              cfg_pad_mode,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic              tap_valid,
    input  logic              tap_ready,
    output logic [DATA_W-1:0] tap_data,
    output logic              tap_last,
    output logic [ADDR_W-1:0] tap_waddr,
    output logic              busy,
    output logic              done
);

    localparam int CW = DIM_W + 2;
    localparam int P  = K / 2;
    localparam int TW = $clog2(K);
    localparam int FW = DATA_W + 1 + ADDR_W;

    typedef logic signed [CW-1:0] coord_t;

    localparam logic [TW-1:0] TAP_MAX = TW'(K - 1);
    localparam coord_t ZERO_C = '0;
    localparam coord_t ONE_C  = coord_t'(1);
    localparam coord_t PAD_C  = coord_t'(P);
    localparam coord_t STEP_C = coord_t'(STRIDE);

    scanState_e        state_q, state_d;
    logic [DIM_W-1:0]  rows_q, rows_d;
    logic [DIM_W-1:0]  cols_q, cols_d;
    logic              mode_q, mode_d;
    logic [TW-1:0]     tapI_q, tapI_d;
    logic [TW-1:0]     tapJ_q, tapJ_d;
    coord_t            rowPos_q, rowPos_d;
    coord_t            colPos_q, colPos_d;
    logic [ADDR_W-1:0] winIdx_q, winIdx_d;
    logic [ADDR_W-1:0] topBase_q, topBase_d;
    logic [ADDR_W-1:0] curBase_q, curBase_d;

    logic              pendValid_q;
    logic              pendZero_q;
    logic              pendLast_q;
    logic [ADDR_W-1:0] pendWaddr_q;

    coord_t            rowsS, colsS, rowHi, colHi;
    coord_t            tapR, tapC, tapColC;
    coord_t            topRowC, nextTopC, rowDelta;
    logic              rowOut, colOut, padTap, rowStepIn;
    logic              lastCol, lastRow, tapLastW;
    logic              dimsOk, issue;
    logic [1:0]        fifoCount, inUse;
    logic [ADDR_W-1:0] tapAddr, baseStep;
    logic [DATA_W-1:0] pushPix;
    logic [FW-1:0]     pushData, popData;

    function automatic coord_t clampCoord(input coord_t v, input coord_t hi);
        if (v < ZERO_C) begin
            return ZERO_C;
        end else if (v > hi) begin
            return hi;
        end
        return v;
    endfunction

    assign rowsS = coord_t'({2'b00, rows_q});
    assign colsS = coord_t'({2'b00, cols_q});
    assign rowHi = rowsS - ONE_C;
    assign colHi = colsS - ONE_C;

    assign tapR = rowPos_q + coord_t'({{(CW-TW){1'b0}}, tapI_q}) - PAD_C;
    assign tapC = colPos_q + coord_t'({{(CW-TW){1'b0}}, tapJ_q}) - PAD_C;

    assign rowOut    = (tapR < ZERO_C) || (tapR > rowHi);
    assign colOut    = (tapC < ZERO_C) || (tapC > colHi);
    assign padTap    = (rowOut || colOut) && (mode_q == PAD_ZERO);
    assign rowStepIn = (tapR >= ZERO_C) && (tapR < rowHi);

    // curBase_q always holds clamp(r)*cols for the current tap row, so the
    // address needs only an add of the clamped column.
    assign tapColC = clampCoord(tapC, colHi);
    assign tapAddr = curBase_q + ADDR_W'(tapColC);

    // Moving down one window row shifts the clamped top row by 0..STRIDE rows.
    assign topRowC  = clampCoord(rowPos_q - PAD_C, rowHi);
    assign nextTopC = clampCoord(rowPos_q + STEP_C - PAD_C, rowHi);
    assign rowDelta = nextTopC - topRowC;

    always_comb begin
        baseStep = '0;
        for (int s = 1; s <= STRIDE; s++) begin
            if (coord_t'(s) <= rowDelta) begin
                baseStep = baseStep + ADDR_W'(cols_q);
            end
        end
    end

    assign lastCol  = (colPos_q + STEP_C) > colHi;
    assign lastRow  = (rowPos_q + STEP_C) > rowHi;
    assign tapLastW = (tapI_q == TAP_MAX) && (tapJ_q == TAP_MAX);

    // Pipeline slot plus FIFO entries never exceed the two FIFO slots.
    assign inUse  = fifoCount + {1'b0, pendValid_q};
    assign dimsOk = (rows_q != '0) && (cols_q != '0);
    assign issue  = (state_q == SCAN) && dimsOk && (inUse < 2'd2);

    assign rd_en   = issue && !padTap;
    assign rd_addr = rd_en ? tapAddr : '0;
    assign busy    = (state_q == SCAN) || (state_q == DRAIN);
    assign done    = (state_q == DONE);

    always_comb begin
        state_d   = state_q;
        rows_d    = rows_q;
        cols_d    = cols_q;
        mode_d    = mode_q;
        tapI_d    = tapI_q;
        tapJ_d    = tapJ_q;
        rowPos_d  = rowPos_q;
        colPos_d  = colPos_q;
        winIdx_d  = winIdx_q;
        topBase_d = topBase_q;
        curBase_d = curBase_q;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d   = SCAN;
                    rows_d    = cfg_rows;
                    cols_d    = cfg_cols;
                    mode_d    = cfg_pad_mode ? PAD_REPL : PAD_ZERO;
                    tapI_d    = '0;
                    tapJ_d    = '0;
                    rowPos_d  = ZERO_C;
                    colPos_d  = ZERO_C;
                    winIdx_d  = '0;
                    topBase_d = '0;
                    curBase_d = '0;
                end
            end
            SCAN: begin
                if (!dimsOk) begin
                    state_d = DONE;
                end else if (issue) begin
                    if (tapI_q != TAP_MAX) begin
                        tapI_d = tapI_q + TW'(1);
                        if (rowStepIn) begin
                            curBase_d = curBase_q + ADDR_W'(cols_q);
                        end
                    end else begin
                        tapI_d    = '0;
                        curBase_d = topBase_q;
                        if (tapJ_q != TAP_MAX) begin
                            tapJ_d = tapJ_q + TW'(1);
                        end else begin
                            tapJ_d   = '0;
                            winIdx_d = winIdx_q + ADDR_W'(1);
                            if (!lastCol) begin
                                colPos_d = colPos_q + STEP_C;
                            end else begin
                                colPos_d  = ZERO_C;
                                rowPos_d  = rowPos_q + STEP_C;
                                topBase_d = topBase_q + baseStep;
                                curBase_d = topBase_q + baseStep;
                                if (lastRow) begin
                                    state_d = DRAIN;
                                end
                            end
                        end
                    end
                end
            end
            DRAIN: begin
                if (!pendValid_q && (fifoCount == 2'd0)) begin
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            rows_q      <= '0;
            cols_q      <= '0;
            mode_q      <= PAD_ZERO;
            tapI_q      <= '0;
            tapJ_q      <= '0;
            rowPos_q    <= ZERO_C;
            colPos_q    <= ZERO_C;
            winIdx_q    <= '0;
            topBase_q   <= '0;
            curBase_q   <= '0;
            pendValid_q <= 1'b0;
            pendZero_q  <= 1'b0;
            pendLast_q  <= 1'b0;
            pendWaddr_q <= '0;
        end else begin
            state_q     <= state_d;
            rows_q      <= rows_d;
            cols_q      <= cols_d;
            mode_q      <= mode_d;
            tapI_q      <= tapI_d;
            tapJ_q      <= tapJ_d;
            rowPos_q    <= rowPos_d;
            colPos_q    <= colPos_d;
            winIdx_q    <= winIdx_d;
            topBase_q   <= topBase_d;
            curBase_q   <= curBase_d;
            pendValid_q <= issue;
            pendZero_q  <= padTap;
            pendLast_q  <= tapLastW;
            pendWaddr_q <= winIdx_q;
        end
    end

    // Padded taps ride the same one-cycle slot as reads so ordering holds.
    assign pushPix  = pendZero_q ? '0 : rd_data;
    assign pushData = {pushPix, pendLast_q, pendWaddr_q};

    conv_tap_fifo #(
        .W (FW)
    ) tapFifo (
        .clk        (clk),
        .rst        (rst),
        .pushEn_i   (pendValid_q),
        .pushData_i (pushData),
        .popEn_i    (tap_ready),
        .valid_o    (tap_valid),
        .popData_o  (popData),
        .count_o    (fifoCount)
    );

    assign {tap_data, tap_last, tap_waddr} = popData;

endmodule

// File: tb/tb_conv_window_scanner.sv
// Scoreboard bench for conv_window_scanner: a K=3/S=1 and a K=5/S=2 instance
// share stimulus; a reference model fills the expected tap queue for each scan.
module tb_conv_window_scanner;

   localparam int ADDR_W = 17;
   localparam int DATA_W = 12;
   localparam int DIM_W  = 8;

   typedef struct packed {
      logic [DATA_W-1:0] data;
      logic              last;
      logic [ADDR_W-1:0] waddr;
   } tap_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic             rst, startA, startB, cfgMode, tapReady, sel;
   logic [DIM_W-1:0] cfgRows, cfgCols;

   logic              rdEnA, tapValidA, tapLastA, busyA, doneA;
   logic [ADDR_W-1:0] rdAddrA, tapWaddrA;
   logic [DATA_W-1:0] rdDataA, tapDataA;
   logic              rdEnB, tapValidB, tapLastB, busyB, doneB;
   logic [ADDR_W-1:0] rdAddrB, tapWaddrB;
   logic [DATA_W-1:0] rdDataB, tapDataB;

   conv_window_scanner #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DIM_W(DIM_W), .K(3), .STRIDE(1)) dutA (
      .clk(clk), .rst(rst), .start(startA), .cfg_rows(cfgRows), .cfg_cols(cfgCols),
      .cfg_pad_mode(cfgMode), .rd_en(rdEnA), .rd_addr(rdAddrA), .rd_data(rdDataA),
      .tap_valid(tapValidA), .tap_ready(tapReady), .tap_data(tapDataA), .tap_last(tapLastA),
      .tap_waddr(tapWaddrA), .busy(busyA), .done(doneA));

   conv_window_scanner #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DIM_W(DIM_W), .K(5), .STRIDE(2)) dutB (
      .clk(clk), .rst(rst), .start(startB), .cfg_rows(cfgRows), .cfg_cols(cfgCols),
      .cfg_pad_mode(cfgMode), .rd_en(rdEnB), .rd_addr(rdAddrB), .rd_data(rdDataB),
      .tap_valid(tapValidB), .tap_ready(tapReady), .tap_data(tapDataB), .tap_last(tapLastB),
      .tap_waddr(tapWaddrB), .busy(busyB), .done(doneB));

   function automatic logic [DATA_W-1:0] memVal(input int a);
      return DATA_W'(a * 37 + 11);
   endfunction

   // Image RAM models with one-cycle latency; a junk value marks unrequested reads.
   always @(posedge clk) begin
      rdDataA <= rdEnA ? memVal(int'(rdAddrA)) : 12'hABC;
      rdDataB <= rdEnB ? memVal(int'(rdAddrB)) : 12'hABC;
   end

   logic curValid, curRdEn, curDone, curBusy;
   tap_t curTap;
   assign curValid = sel ? tapValidB : tapValidA;
   assign curRdEn  = sel ? rdEnB : rdEnA;
   assign curDone  = sel ? doneB : doneA;
   assign curBusy  = sel ? busyB : busyA;
   assign curTap   = sel ? {tapDataB, tapLastB, tapWaddrB} : {tapDataA, tapLastA, tapWaddrA};

   tap_t expQ[$];
   int   checkCount = 0;
   int   passCount  = 0;
   int   rdTotal    = 0;
   int   readyPct   = 100;
   bit   held       = 1'b0;
   tap_t heldTap;

   task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
      checkCount++;
      if (actual === expected) begin
         passCount++;
      end else begin
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
      end
   endtask

   // Runs at the falling edge, so handshakes seen here are the ones the next rising edge takes.
   task automatic observe();
      tap_t expTap;
      if (rst) begin
         held = 1'b0;
         return;
      end
      if (curRdEn) rdTotal++;
      if (held) begin
         checkOutput("hold stable", {curValid, curTap}, {1'b1, heldTap});
         held = 1'b0;
      end
      if (curValid && tapReady) begin
         if (expQ.size() == 0) begin
            checkOutput("unexpected tap", 1, 0);
         end else begin
            expTap = expQ.pop_front();
            checkOutput("tap", curTap, expTap);
         end
      end else if (curValid) begin
         held    = 1'b1;
         heldTap = curTap;
      end
   endtask

   task automatic cycleStep();
      @(negedge clk);
      observe();
      @(posedge clk);
      #1;
      tapReady = ($urandom_range(99) < readyPct);
   endtask

   task automatic buildModel(input bit useB, input int rows, input int cols, input bit mode, output int reads);
      int   kk   = useB ? 5 : 3;
      int   ss   = useB ? 2 : 1;
      int   pp   = kk / 2;
      int   widx = 0;
      tap_t t;
      reads = 0;
      for (int rp = 0; rp < rows; rp += ss) begin
         for (int cp = 0; cp < cols; cp += ss) begin
            for (int j = 0; j < kk; j++) begin
               for (int i = 0; i < kk; i++) begin
                  int r   = rp + i - pp;
                  int c   = cp + j - pp;
                  bit oor = (r < 0) || (r >= rows) || (c < 0) || (c >= cols);
                  if (oor && !mode) begin
                     t.data = '0;
                  end else begin
                     r = (r < 0) ? 0 : ((r >= rows) ? rows - 1 : r);
                     c = (c < 0) ? 0 : ((c >= cols) ? cols - 1 : c);
                     t.data = memVal(r * cols + c);
                     reads++;
                  end
                  t.last  = (i == kk - 1) && (j == kk - 1);
                  t.waddr = ADDR_W'(widx);
                  expQ.push_back(t);
               end
            end
            widx++;
         end
      end
   endtask

   task automatic applyStimulus(input bit useB, input int rows, input int cols, input bit mode,
                                input int pct, input bit midStart, output int doneAt);
      int expReads, rdStart;
      sel      = useB;
      readyPct = pct;
      cfgRows  = DIM_W'(rows);
      cfgCols  = DIM_W'(cols);
      cfgMode  = mode;
      buildModel(useB, rows, cols, mode, expReads);
      rdStart = rdTotal;
      if (useB) startB = 1'b1; else startA = 1'b1;
      cycleStep();
      startA  = 1'b0;
      startB  = 1'b0;
      cfgRows = 8'hFF;
      cfgCols = 8'hFF;
      cfgMode = ~mode;
      doneAt  = -1;
      for (int cyc = 1; cyc <= 3000; cyc++) begin
         if (useB) startB = midStart && (cyc == 10); else startA = midStart && (cyc == 10);
         cycleStep();
         if (curDone) begin
            doneAt = cyc;
            break;
         end
      end
      startA = 1'b0;
      startB = 1'b0;
      checkOutput("done seen", doneAt > 0, 1);
      checkOutput("busy at done", curBusy, 0);
      checkOutput("taps left", expQ.size(), 0);
      checkOutput("read count", rdTotal - rdStart, expReads);
      expQ.delete();
   endtask

   initial begin
      #1ms;
      $display("[TB] FAIL watchdog: time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int doneAt, dummy;
      rst = 1'b1; startA = 1'b0; startB = 1'b0; sel = 1'b0;
      cfgRows = '0; cfgCols = '0; cfgMode = 1'b0; tapReady = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("reset A", {rdEnA, rdAddrA, tapValidA, tapDataA, tapLastA, tapWaddrA, busyA, doneA}, 0);
      checkOutput("reset B", {rdEnB, rdAddrB, tapValidB, tapDataB, tapLastB, tapWaddrB, busyB, doneB}, 0);
      rst = 1'b0;

      $display("[TB] 4x4 K3 zero / replicate");
      applyStimulus(1'b0, 4, 4, 1'b0, 100, 1'b0, doneAt);
      applyStimulus(1'b0, 4, 4, 1'b1, 100, 1'b0, doneAt);
      $display("[TB] 5x7 K5 stride 2");
      applyStimulus(1'b1, 5, 7, 1'b0, 100, 1'b0, doneAt);
      applyStimulus(1'b1, 5, 7, 1'b1, 50, 1'b0, doneAt);
      $display("[TB] random backpressure");
      applyStimulus(1'b0, 6, 5, 1'b0, 50, 1'b0, doneAt);
      applyStimulus(1'b0, 7, 3, 1'b1, 50, 1'b0, doneAt);
      applyStimulus(1'b1, 9, 6, 1'b0, 50, 1'b0, doneAt);
      applyStimulus(1'b0, 1, 1, 1'b1, 50, 1'b0, doneAt);
      $display("[TB] empty images and mid-scan start");
      applyStimulus(1'b0, 0, 4, 1'b0, 100, 1'b0, doneAt);
      checkOutput("zero-dim latency", doneAt, 1);
      applyStimulus(1'b1, 3, 0, 1'b1, 100, 1'b0, doneAt);
      checkOutput("zero-dim latency B", doneAt, 1);
      applyStimulus(1'b0, 4, 4, 1'b0, 70, 1'b1, doneAt);

      $display("[TB] reset mid-window");
      sel = 1'b0; readyPct = 50;
      cfgRows = 8'd4; cfgCols = 8'd4; cfgMode = 1'b0;
      buildModel(1'b0, 4, 4, 1'b0, dummy);
      startA = 1'b1;
      cycleStep();
      startA = 1'b0;
      repeat (25) cycleStep();
      rst = 1'b1;
      cycleStep();
      checkOutput("reset mid-scan", {rdEnA, rdAddrA, tapValidA, tapDataA, tapLastA, tapWaddrA, busyA, doneA}, 0);
      rst = 1'b0;
      expQ.delete();
      applyStimulus(1'b0, 4, 4, 1'b1, 60, 1'b0, doneAt);

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
